mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MMIO_ADDR, default 32'hFFFFFFF0, word address of the test status register; it is never forwarded to memory.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  instruction-fetch request; held until i_ack.
REQ-005 i_addr  input  32  fetch byte address; stable while i_req.
REQ-006 i_ack  output  1  one-cycle pulse; fetch complete, i_rdata valid.
REQ-007 i_rdata  output  32  fetch data.
REQ-008 d_req  input  1  data request; held until d_ack.
REQ-009 d_we  input  1  1 = write, 0 = read; stable while d_req.
REQ-010 d_addr  input  32  data byte address; stable while d_req.
REQ-011 d_wdata  input  32  write data; stable while d_req.
REQ-012 d_ack  output  1  one-cycle pulse; data access complete.
REQ-013 d_rdata  output  32  read data, valid with d_ack.
REQ-014 m_en  output  1  memory access strobe.
REQ-015 m_we  output  1  memory write enable, qualified by m_en.
REQ-016 m_addr  output  32  memory byte address.
REQ-017 m_wdata  output  32  memory write data.
REQ-018 m_rdata  input  32  memory read data, valid the cycle after m_en.
REQ-019 done  output  1  sticky; set by any write to MMIO_ADDR.
REQ-020 pass  output  1  sticky; value of (wdata == 1) at the first MMIO write.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req, ACCESS->RESP always, RESP->IDLE always.
REQ-022 In IDLE, the winner is selected and its address, we and wdata are latched into registers; the instruction port always latches we=0.
REQ-023 ACCESS: m_en=1, m_we=latched we, m_addr/m_wdata from latches, for exactly one cycle; m_en=0 in all other states.
REQ-024 RESP: winner's ack=1 for exactly one cycle, rdata=m_rdata; the loser's ack stays 0.
REQ-025 Latency: req sampled in IDLE at cycle N -> m_en at N+1 -> ack at N+2; next arbitration no earlier than N+3.
REQ-026 Requests are sampled only in IDLE; a req rising in ACCESS/RESP waits.
REQ-027 Simultaneous requests resolve per REQ-037/038; a lone request always wins.
REQ-028 Latched d_addr[31:2] == MMIO_ADDR[31:2]: ACCESS drives m_en=0; a write sets done=1, and pass=(wdata==32'd1) only if done was 0; a read returns {30'b0, pass, done}.
REQ-029 Fetches to MMIO_ADDR go to memory normally.
REQ-030 Port rdata outputs hold their last value outside RESP.
REQ-031 A requester dropping req before ack is an illegal stimulus; the transaction still completes and acks.

Reset
REQ-032 reset forces state IDLE, i_ack=0, d_ack=0, m_en=0, m_we=0, done=0, pass=0, last-grant=data (instruction wins the first tie).
REQ-033 m_addr, m_wdata, i_rdata, d_rdata reset to 32'h0.
REQ-034 Reset during ACCESS or RESP abandons the transaction: no ack is issued, and a memory write is not issued if reset is sampled in the IDLE->ACCESS edge.
REQ-035 reset takes priority over every other event in the same cycle.
REQ-036 First arbitration occurs in the first IDLE cycle after reset deasserts.

Configuration
REQ-037 MEM_ARBITER_RR_EN defined: round-robin; on a tie the port not granted last wins; last-grant updates on every grant.
REQ-038 MEM_ARBITER_RR_EN undefined: fixed priority, data port wins every tie; last-grant register is absent.

Verification
REQ-039 Fetch only: i_req, i_addr=0x10, memory word 4 = 0x00500093 -> m_en at N+1 with m_addr=0x10, i_ack at N+2 with i_rdata=0x00500093.
REQ-040 Data write then read: write 0xDEADBEEF to 0x100, then read 0x100 -> m_we=1 once, d_rdata=0xDEADBEEF, 3 cycles per access.
REQ-041 Tie, both held 4 transactions: RR_EN -> grants I,D,I,D; undefined -> grants D,D,D,D, i_ack never asserted.
REQ-042 MMIO write 1 to 0xFFFFFFF0 -> m_en stays 0, d_ack at N+2, done=1, pass=1; a second write of 0 leaves pass=1; a read returns 0x3.
REQ-043 MMIO write 7 after reset -> done=1, pass=0; a read returns 0x1.
REQ-044 reset asserted in ACCESS of a write -> no ack; next cycle IDLE, done=0, all acks 0; a re-issued request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter onto a single memory with an MMIO test status register.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; default is fixed data-port priority.
module mem_arbiter #(
  parameter logic [31:0] MMIO_ADDR = 32'hFFFFFFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        done,
  output logic        pass
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic sel_d, lat_we, win_d, mmio, grant;
  logic [31:0] lat_addr, lat_wdata, i_hold, d_hold;

  assign grant = state == IDLE && (i_req || d_req);
`ifdef MEM_ARBITER_RR_EN
  logic last_d;
  always_ff @(posedge clock) begin
    if (reset) last_d <= 1'b1;
    else if (grant) last_d <= win_d;
  end
  assign win_d = d_req && (!i_req || !last_d);
`else
  assign win_d = d_req;
`endif

  assign mmio = sel_d && lat_addr[31:2] == MMIO_ADDR[31:2];
  assign m_addr = lat_addr;
  assign m_wdata = lat_wdata;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state == IDLE ? (grant ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_d <= 1'b0;
      lat_we <= 1'b0;
      lat_addr <= 32'h0;
      lat_wdata <= 32'h0;
      done <= 1'b0;
      pass <= 1'b0;
      i_hold <= 32'h0;
      d_hold <= 32'h0;
    end else begin
      if (grant) begin
        sel_d <= win_d;
        lat_we <= win_d && d_we;
        lat_addr <= win_d ? d_addr : i_addr;
        lat_wdata <= win_d ? d_wdata : 32'h0;
      end
      // pass records only the first status write; done is sticky
      if (state == ACCESS && mmio && lat_we) begin
        done <= 1'b1;
        if (!done) pass <= lat_wdata == 32'd1;
      end
      i_hold <= i_rdata;
      d_hold <= d_rdata;
    end
  end

  always_comb begin
    m_en = state == ACCESS && !mmio;
    m_we = m_en && lat_we;
    i_ack = state == RESP && !sel_d;
    d_ack = state == RESP && sel_d;
    i_rdata = i_ack ? m_rdata : i_hold;
    d_rdata = d_ack ? (mmio ? {30'b0, pass, done} : m_rdata) : d_hold;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small word memory model.
module tb_mem_arbiter;
  logic clock = 1'b0, reset;
  logic i_req, d_req, d_we, i_ack, d_ack, m_en, m_we, done, pass;
  logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [31:0] mem [0:255];
  int n_checks = 0, n_fail = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .done(done), .pass(pass)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) begin
      mem[4] <= 32'h00500093;
      mem[8'hC0] <= 32'h0;
    end else if (m_en) begin
      if (m_we) mem[m_addr[9:2]] <= m_wdata;
      m_rdata <= mem[m_addr[9:2]];
    end
  end

  task automatic apply_reset;
    @(posedge clock);
    #1 reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Drives one data transaction; lat is cycles from the sampling IDLE cycle to d_ack, -1 on timeout.
  task automatic data_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output int lat, output int men, output int mwe);
    d_req = 1'b1;
    d_we = we;
    d_addr = addr;
    d_wdata = wdata;
    rd = 32'h0;
    lat = -1;
    men = 0;
    mwe = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (m_en) men++;
      if (m_we) mwe++;
      if (d_ack) begin
        rd = d_rdata;
        lat = k - 1;
        break;
      end
    end
    d_req = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({i_ack, d_ack, m_en, m_we, done, pass} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000", {i_ack, d_ack, m_en, m_we, done, pass});
    end
    n_checks++;
    if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: m_addr=%h m_wdata=%h i_rdata=%h d_rdata=%h want 0", m_addr, m_wdata, i_rdata, d_rdata);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_fetch;
    i_req = 1'b1;
    i_addr = 32'h10;
    @(negedge clock);
    n_checks++;
    if (m_en !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_men: got %b want 0", m_en); end
    @(negedge clock);
    n_checks++;
    if ({m_en, m_we, m_addr} !== {2'b10, 32'h10}) begin
      n_fail++;
      $display("FAIL fetch_access: m_en=%b m_we=%b m_addr=%h want 1 0 00000010", m_en, m_we, m_addr);
    end
    @(negedge clock);
    n_checks++;
    if ({i_ack, d_ack, i_rdata} !== {2'b10, 32'h00500093}) begin
      n_fail++;
      $display("FAIL fetch_resp: i_ack=%b d_ack=%b i_rdata=%h want 1 0 00500093", i_ack, d_ack, i_rdata);
    end
    i_req = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({i_ack, i_rdata} !== {1'b0, 32'h00500093}) begin
      n_fail++;
      $display("FAIL fetch_hold: i_ack=%b i_rdata=%h want 0 00500093", i_ack, i_rdata);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_write_read;
    logic [31:0] rd;
    int lat, men, mwe;
    data_xfer(1'b1, 32'h100, 32'hDEADBEEF, rd, lat, men, mwe);
    n_checks++;
    if (lat !== 2 || men !== 1 || mwe !== 1) begin
      n_fail++;
      $display("FAIL write_timing: lat=%0d m_en=%0d m_we=%0d want 2 1 1", lat, men, mwe);
    end
    n_checks++;
    if (mem[64] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_mem: got %h want deadbeef", mem[64]); end
    data_xfer(1'b0, 32'h100, 32'h0, rd, lat, men, mwe);
    n_checks++;
    if (rd !== 32'hDEADBEEF || lat !== 2 || mwe !== 0) begin
      n_fail++;
      $display("FAIL read_back: d_rdata=%h lat=%0d m_we=%0d want deadbeef 2 0", rd, lat, mwe);
    end
  endtask

  task automatic test_tie;
    logic [3:0] gd = 4'b0;
    logic [3:0] want_gd;
    int got = 0, both = 0, n_i = 0, want_i;
`ifdef MEM_ARBITER_RR_EN
    want_gd = 4'b1010;
    want_i = 2;
`else
    want_gd = 4'b1111;
    want_i = 0;
`endif
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int k = 0; k < 20 && got < 4; k++) begin
      @(negedge clock);
      if (i_ack && d_ack) both++;
      if (i_ack) n_i++;
      if (i_ack || d_ack) begin
        gd[got] = d_ack;
        got++;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    n_checks++;
    if (got !== 4 || both !== 0) begin n_fail++; $display("FAIL tie_count: acks=%0d both=%0d want 4 0", got, both); end
    n_checks++;
    if (gd !== want_gd) begin n_fail++; $display("FAIL tie_order: grants(bit0 first, 1=D)=%b want %b", gd, want_gd); end
    n_checks++;
    if (n_i !== want_i) begin n_fail++; $display("FAIL tie_iack: i_ack count=%0d want %0d", n_i, want_i); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_mmio_fail;
    logic [31:0] rd;
    int lat, men, mwe;
    apply_reset;
    data_xfer(1'b1, 32'hFFFFFFF0, 32'd7, rd, lat, men, mwe);
    n_checks++;
    if (lat !== 2 || men !== 0 || done !== 1'b1 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL mmio7_write: lat=%0d m_en=%0d done=%b pass=%b want 2 0 1 0", lat, men, done, pass);
    end
    data_xfer(1'b0, 32'hFFFFFFF0, 32'h0, rd, lat, men, mwe);
    n_checks++;
    if (rd !== 32'h1 || men !== 0) begin n_fail++; $display("FAIL mmio7_read: d_rdata=%h m_en=%0d want 1 0", rd, men); end
  endtask

  task automatic test_mmio_pass;
    logic [31:0] rd;
    int lat, men, mwe;
    apply_reset;
    n_checks++;
    if (done !== 1'b0 || pass !== 1'b0) begin n_fail++; $display("FAIL mmio_reset: done=%b pass=%b want 0 0", done, pass); end
    data_xfer(1'b1, 32'hFFFFFFF0, 32'd1, rd, lat, men, mwe);
    n_checks++;
    if (lat !== 2 || men !== 0 || done !== 1'b1 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL mmio1_write: lat=%0d m_en=%0d done=%b pass=%b want 2 0 1 1", lat, men, done, pass);
    end
    data_xfer(1'b1, 32'hFFFFFFF0, 32'd0, rd, lat, men, mwe);
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b1) begin n_fail++; $display("FAIL mmio_sticky: done=%b pass=%b want 1 1", done, pass); end
    data_xfer(1'b0, 32'hFFFFFFF0, 32'h0, rd, lat, men, mwe);
    n_checks++;
    if (rd !== 32'h3) begin n_fail++; $display("FAIL mmio1_read: d_rdata=%h want 3", rd); end
  endtask

  task automatic test_reset_access;
    logic [31:0] rd;
    int lat, men, mwe;
    apply_reset;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hFFFFFFF0; d_wdata = 32'd1;
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (m_en !== 1'b0) begin n_fail++; $display("FAIL rst_acc_men: got %b want 0", m_en); end
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      n_checks++;
      if ({i_ack, d_ack, m_en, done} !== 4'b0) begin
        n_fail++;
        $display("FAIL rst_acc_after%0d: i_ack=%b d_ack=%b m_en=%b done=%b want 0000", k, i_ack, d_ack, m_en, done);
      end
    end
    @(posedge clock);
    #1;
    data_xfer(1'b1, 32'hFFFFFFF0, 32'd1, rd, lat, men, mwe);
    n_checks++;
    if (lat !== 2 || done !== 1'b1 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_acc_reissue: lat=%0d done=%b pass=%b want 2 1 1", lat, done, pass);
    end
  endtask

  task automatic test_reset_edge;
    int men = 0, acks = 0;
    apply_reset;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hA5A5A5A5;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (m_en) men++;
      if (i_ack || d_ack) acks++;
    end
    n_checks++;
    if (men !== 0 || acks !== 0 || mem[8'hC0] !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_edge: m_en=%0d acks=%0d mem=%h want 0 0 0", men, acks, mem[8'hC0]);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_write_read;
    test_tie;
    test_mmio_fail;
    test_mmio_pass;
    test_reset_access;
    test_reset_edge;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
